europa_sd_dac: RTL and testbench



---
 rtl/europa_sd_dac_if.sv | 21 ++
 rtl/europa_sd_dac.sv | 111 +++++++++++
 tb/tb_europa_sd_dac.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/europa_sd_dac_if.sv
// Sample stream into the europa delta-sigma DAC: unsigned offset-binary data with
// a valid/ready handshake.
interface europa_sd_dac_if #(
   parameter int unsigned DATA_BITS = 7
);
   logic [DATA_BITS-1:0] s_data;
   logic                 s_valid;
   logic                 s_ready;

   modport master (
      output s_data,
      output s_valid,
      input  s_ready
   );

   modport slave (
      input  s_data,
      input  s_valid,
      output s_ready
   );
endinterface

// File: rtl/europa_sd_dac.sv
// First-order delta-sigma audio DAC: a sample FIFO feeds a hold register once per
// sample period, and the hold value sets the pulse density on dac_out.
module europa_sd_dac #(
   parameter int unsigned DATA_BITS  = 7,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned SAMPLE_DIV = 128
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   europa_sd_dac_if.slave                s,
   input  logic                          clear_underflow,
   output logic                          underflow,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          dac_out
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   localparam logic [LW-1:0]        FULL_LEVEL = LW'(FIFO_DEPTH);
   localparam logic [DW-1:0]        DIV_LAST   = DW'(SAMPLE_DIV - 1);
   localparam logic [DATA_BITS-1:0] MIDSCALE   = {1'b1, {(DATA_BITS-1){1'b0}}};

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]        wptr_q, rptr_q;
   logic [LW-1:0]        level_q, level_d;
   logic [DW-1:0]        div_q, div_d;
   logic [DATA_BITS-1:0] hold_q, acc_q;
   logic                 dac_q, underflow_q;

   logic                 full, empty, tick, push, pop;
   logic [DATA_BITS:0]   sum;

   // Ready comes from the registered level only, so a pop never opens it in the same cycle.
   always_comb begin
      full  = (level_q == FULL_LEVEL);
      empty = (level_q == '0);
      tick  = enable && (div_q == DIV_LAST);
      push  = s.s_valid && !full;
      pop   = tick && !empty;
      sum   = {1'b0, acc_q} + {1'b0, hold_q};

      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      div_d = '0;
      if (enable && (div_q != DIV_LAST)) begin
         div_d = div_q + DW'(1);
      end
   end

   assign s.s_ready = !full;
   assign level     = level_q;
   assign underflow = underflow_q;
   assign dac_out   = dac_q;

   // Storage needs no reset; the pointers and level define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= s.s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         div_q   <= '0;
         hold_q  <= MIDSCALE;
      end else begin
         level_q <= level_d;
         div_q   <= div_d;
         if (push) begin
            wptr_q <= wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PW'(1);
            hold_q <= mem_q[rptr_q];
         end
      end
   end

   // An underflow event in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         underflow_q <= 1'b0;
      end else if (tick && empty) begin
         underflow_q <= 1'b1;
      end else if (clear_underflow) begin
         underflow_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         acc_q <= '0;
         dac_q <= 1'b0;
      end else begin
         acc_q <= sum[DATA_BITS-1:0];
         dac_q <= sum[DATA_BITS];
      end
   end

endmodule

// File: tb/tb_europa_sd_dac.sv
// Bench for europa_sd_dac: a queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed densities and flag values.
module tb_europa_sd_dac;
   localparam int DB = 7;
   localparam int FD = 4;
   localparam int SD = 128;
   localparam int FS = 2 ** DB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       clear_underflow = 1'b0;
   logic       underflow;
   logic       dac_out;
   logic [2:0] level;

   europa_sd_dac_if #(.DATA_BITS(DB)) sif ();

   europa_sd_dac #(
      .DATA_BITS (DB),
      .FIFO_DEPTH(FD),
      .SAMPLE_DIV(SD)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .s              (sif),
      .clear_underflow(clear_underflow),
      .underflow      (underflow),
      .level          (level),
      .dac_out        (dac_out)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: sample queue, hold value, and accumulator modulo full scale.
   int mq[$];
   int m_hold = FS / 2;
   int m_acc = 0;
   int m_dac = 0;
   int m_div = 0;
   int m_uf = 0;
   int m_sum;
   bit m_tick, m_was_empty, m_was_full;

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         m_hold = FS / 2;
         m_acc  = 0;
         m_dac  = 0;
         m_div  = 0;
         m_uf   = 0;
      end else begin
         m_tick      = enable && (m_div == SD - 1);
         m_was_empty = (mq.size() == 0);
         m_was_full  = (mq.size() == FD);
         if (enable) begin
            m_sum = m_acc + m_hold;
            m_dac = (m_sum >= FS) ? 1 : 0;
            m_acc = m_sum % FS;
         end else begin
            m_acc = 0;
            m_dac = 0;
         end
         if (m_tick && !m_was_empty) m_hold = mq.pop_front();
         if (m_tick && m_was_empty) m_uf = 1;
         else if (clear_underflow) m_uf = 0;
         if (sif.s_valid && !m_was_full) mq.push_back(int'(sif.s_data));
         m_div = enable ? (m_div + 1) % SD : 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_dac_out", dac_out, m_dac);
         check("cyc_s_ready", sif.s_ready, (mq.size() != FD));
         check("cyc_level", level, mq.size());
         check("cyc_underflow", underflow, m_uf);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enable = 1'b0;
      sif.s_valid = 1'b0;
      clear_underflow = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic push(input int v);
      sif.s_data = DB'(v);
      sif.s_valid = 1'b1;
      step();
      sif.s_valid = 1'b0;
   endtask

   task automatic count_win(input int skip, input int n, output int ones, output int trans);
      logic prev;
      ones = 0;
      trans = 0;
      prev = 1'b0;
      repeat (skip) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (dac_out === 1'b1) ones++;
         if (i > 0 && dac_out !== prev) trans++;
         prev = dac_out;
      end
   endtask

   int ones, trans;

   initial begin
      sif.s_data = '0;
      sif.s_valid = 1'b0;

      // 1: reset values, then midscale with an empty FIFO
      do_reset();
      chk_en = 1'b1;
      check("t1_rst_dac", dac_out, 0);
      check("t1_rst_ready", sif.s_ready, 1);
      check("t1_rst_level", level, 0);
      check("t1_rst_underflow", underflow, 0);
      enable = 1'b1;
      count_win(2, 128, ones, trans);
      check("t1_mid_ones", ones, 64);
      check("t1_mid_alternate", trans, 127);
      check("t1_underflow_set", underflow, 1);

      // 2: extremes 0 and 127
      do_reset();
      push(0);
      push(127);
      check("t2_level", level, 2);
      enable = 1'b1;
      count_win(129, 128, ones, trans);
      check("t2_zero_ones", ones, 0);
      count_win(1, 128, ones, trans);
      check("t2_max_ones", ones, 127);

      // 3: fill while disabled, full backpressure, refill after the first pop
      do_reset();
      sif.s_valid = 1'b1;
      sif.s_data = 7'd10; step();
      sif.s_data = 7'd20; step();
      sif.s_data = 7'd30; step();
      sif.s_data = 7'd40; step();
      sif.s_data = 7'd50;
      check("t3_full_level", level, 4);
      check("t3_full_ready", sif.s_ready, 0);
      repeat (3) step();
      check("t3_held_level", level, 4);
      enable = 1'b1;
      repeat (128) step();
      check("t3_pop_level", level, 3);
      check("t3_pop_ready", sif.s_ready, 1);
      step();
      check("t3_refill_level", level, 4);
      check("t3_refill_ready", sif.s_ready, 0);
      sif.s_valid = 1'b0;

      // 4: underflow set, clear, and set-wins-over-clear
      do_reset();
      push(96);
      enable = 1'b1;
      repeat (128) step();
      check("t4_tick1_underflow", underflow, 0);
      check("t4_tick1_level", level, 0);
      count_win(2, 128, ones, trans);
      check("t4_repeat_ones", ones, 96);
      check("t4_tick2_underflow", underflow, 1);
      step();
      clear_underflow = 1'b1;
      step();
      clear_underflow = 1'b0;
      check("t4_cleared", underflow, 0);
      repeat (124) step();
      clear_underflow = 1'b1;
      step();
      check("t4_set_wins", underflow, 1);
      clear_underflow = 1'b0;

      // 5: reset mid-stream
      do_reset();
      push(20);
      enable = 1'b1;
      repeat (128) step();
      enable = 1'b0;
      push(1);
      push(2);
      push(3);
      check("t5_level3", level, 3);
      enable = 1'b1;
      repeat (5) step();
      reset = 1'b1;
      step();
      check("t5_rst_level", level, 0);
      check("t5_rst_ready", sif.s_ready, 1);
      check("t5_rst_dac", dac_out, 0);
      reset = 1'b0;
      count_win(2, 128, ones, trans);
      check("t5_mid_ones", ones, 64);

      // 6: enable toggle mid period
      do_reset();
      push(40);
      enable = 1'b1;
      repeat (128) step();
      push(7);
      check("t6_level1", level, 1);
      repeat (20) step();
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t6_disabled_dac", dac_out, 0);
      end
      check("t6_disabled_level", level, 1);
      enable = 1'b1;
      repeat (127) step();
      check("t6_pre_tick_level", level, 1);
      step();
      check("t6_tick_level", level, 0);
      count_win(2, 128, ones, trans);
      check("t6_hold7_ones", ones, 7);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
